mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin N:1 arbiter between several MemoryBus masters (ray tracer memory port, frame-buffer scanout, loader) and the single memory-controller slave port. Requests pass through one registered stage with full throughput. Responses are routed back combinationally to the owning master by response ID range.

## Interface
- `NUM_MASTERS`, 2: number of upstream master ports (2..8).
- `DATA_WIDTH`, 24: bus data width.
- `ADDRESS_WIDTH`, 32: bus address width.
- `MASTER_ID_WIDTH`, 8: transaction ID width.
- `ID_SPAN`, 4: IDs per port. Port i owns IDs [i*ID_SPAN, (i+1)*ID_SPAN).

Ports:
- `clock`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `umsID/umsAddress/umsData/umsWrite/umsValid`  in  [NUM_MASTERS] x field width  upstream requests.
- `umsTaken`  out  [NUM_MASTERS]  request accepted this cycle.
- `usmID/usmData/usmValid`  out  [NUM_MASTERS] x field width  responses to each master.
- `usmTaken`  in  [NUM_MASTERS]  master accepts response.
- `dmsID/dmsAddress/dmsData/dmsWrite/dmsValid`  out  field widths  request to memory slave.
- `dmsTaken`  in  1  slave accepts request.
- `dsmID/dsmData/dsmValid`  in  field widths  response from slave.
- `dsmTaken`  out  1  arbiter accepts response.
- `dropPulse`  out  1  one-cycle pulse when a response with an unowned ID is discarded.

## Operation
- Handshake: a transfer occurs in any cycle where Valid and Taken are both high. A producer holds Valid and payload stable until the transfer.
- Request stage: one output register (`dms*`). `load = !dmsValid || dmsTaken`.
- Grant: combinational, round-robin. Search starts at port `last+1` mod N, and the first port with `umsValid` wins. `umsTaken[w] = load && umsValid[w]` for the winner only; every other `umsTaken` is 0.
- On a load with a winner, the winner's fields are captured into `dms*`, `dmsValid` is set to 1, and `last` is set to w.
- On a load with no winner, `dmsValid` is cleared to 0 and `last` is unchanged.
- A pending `dms*` never changes while `dmsValid && !dmsTaken`.
- Response path is purely combinational:
  - Owner index is `o = dsmID / ID_SPAN`.
  - If `o < NUM_MASTERS`: `usmValid[o] = dsmValid`, `usmID[o]/usmData[o]` are driven from `dsm*`, and `dsmTaken = usmTaken[o]`. All other `usmValid` are 0.
  - If `o >= NUM_MASTERS`: `dsmTaken = 1`, all `usmValid` are 0, and `dropPulse = dsmValid` (registered, so it appears one cycle later).
- IDs are never rewritten. Masters must issue IDs only within their own range.

## Timing
- Reset values: `dmsValid=0`, `dms*` payload=0, `last=NUM_MASTERS-1` (port 0 has first priority), `dropPulse=0`. Combinational outputs follow their inputs.
- Request latency: `umsTaken` in cycle t means `dmsValid=1` from t+1.
- Throughput: one request per cycle when `dmsTaken` is held high.
- Backpressure: if `dmsTaken` is low, all `umsTaken` are 0 and the held request stays.
- Simultaneous `dmsTaken` and a new winner: the register is replaced in the same edge with no bubble.
- Response latency: 0 cycles. A `dsmTaken`→`dsmValid` loop through the arbiter is forbidden; masters must not make `usmTaken` depend on anything other than `usmValid`.
- Reset asserted mid-transfer: a pending `dms*` is discarded immediately. Upstream masters must re-issue.
- Fairness: with all ports continuously valid and `dmsTaken=1`, grants rotate 0,1,…,N-1,0; no port waits more than N-1 grants.

## Structure
- Shared `BusPkg` holds the request struct (ID, address, data, write) and response struct (ID, data) parameterised by the widths, plus `function ownerOf(id)`.
- Natural sub-module: `rr_grant`, a combinational round-robin priority picker taking `valid[N]` and `last`, returning `winner` and `any`.
- Top level holds the output register, the `last` pointer, the response demux and the drop-pulse flop.

## Test plan
- Single request: port 0 writes addr 0x100, data 0xABCDEF, ID 0, with `dmsTaken=1` → `umsTaken[0]` in cycle 1, `dms*` matches in cycle 2, `dmsValid` drops in cycle 3.
- Contention: both ports valid continuously for 6 cycles with `dmsTaken=1` → grant order 0,1,0,1,0,1 and back-to-back `dmsValid`.
- Backpressure: `dmsTaken=0` for 5 cycles while both ports are valid → `dms*` stable, all `umsTaken=0`. Release → next grant goes to the port after the held one.
- Response routing:
  - `dsmID=5`, `usmTaken[1]=1` → `usmValid[1]=1` and `dsmTaken=1` in the same cycle.
  - `dsmID=2` with `usmTaken[0]=0` → `dsmTaken=0` until port 0 accepts.
- Unowned ID: `dsmID=0x40` with N=2 → `dsmTaken=1`, no `usmValid`, `dropPulse=1` the next cycle.
- Reset mid-operation: assert `reset` low while `dmsValid=1` → `dmsValid=0` immediately. After release, port 0 gets first grant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default bus widths and the
// response-ID ownership helper.
package mem_arbiter_pkg;

   localparam int unsigned DEF_NUM_MASTERS     = 2;
   localparam int unsigned DEF_DATA_WIDTH      = 24;
   localparam int unsigned DEF_ADDRESS_WIDTH   = 32;
   localparam int unsigned DEF_MASTER_ID_WIDTH = 8;
   localparam int unsigned DEF_ID_SPAN         = 4;

   // Port index that owns a transaction ID; may be >= the port count for unowned IDs.
   function automatic int unsigned owner_of(input int unsigned id, input int unsigned span);
      return id / span;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_grant.sv
// Combinational round-robin picker: search starts one past the last winner
// and wraps; the first valid port found wins.
module mem_arbiter_rr_grant #(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] valid,
   input  logic [IDX_W-1:0]       last,
   output logic [IDX_W-1:0]       winner,
   output logic                   any
);

   // Walk ports in rotating priority order, keep the first valid one.
   always_comb begin
      logic [IDX_W-1:0] v_idx;
      winner = '0;
      any    = 1'b0;
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
         v_idx = IDX_W'((32'(last) + k) % NUM_MASTERS);
         if (!any && valid[v_idx]) begin
            winner = v_idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// N:1 round-robin MemoryBus arbiter. Requests pass through one output
// register with full throughput; responses are demuxed combinationally back
// to the owning master by ID range.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS     = DEF_NUM_MASTERS,
   parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int unsigned ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
   parameter int unsigned MASTER_ID_WIDTH = DEF_MASTER_ID_WIDTH,
   parameter int unsigned ID_SPAN         = DEF_ID_SPAN
) (
   input  logic                                          clock,
   input  logic                                          reset,
   // upstream requests
   input  logic [NUM_MASTERS-1:0][MASTER_ID_WIDTH-1:0]   umsID,
   input  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0]     umsAddress,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]        umsData,
   input  logic [NUM_MASTERS-1:0]                        umsWrite,
   input  logic [NUM_MASTERS-1:0]                        umsValid,
   output logic [NUM_MASTERS-1:0]                        umsTaken,
   // upstream responses
   output logic [NUM_MASTERS-1:0][MASTER_ID_WIDTH-1:0]   usmID,
   output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]        usmData,
   output logic [NUM_MASTERS-1:0]                        usmValid,
   input  logic [NUM_MASTERS-1:0]                        usmTaken,
   // downstream request
   output logic [MASTER_ID_WIDTH-1:0]                    dmsID,
   output logic [ADDRESS_WIDTH-1:0]                      dmsAddress,
   output logic [DATA_WIDTH-1:0]                         dmsData,
   output logic                                          dmsWrite,
   output logic                                          dmsValid,
   input  logic                                          dmsTaken,
   // downstream response
   input  logic [MASTER_ID_WIDTH-1:0]                    dsmID,
   input  logic [DATA_WIDTH-1:0]                         dsmData,
   input  logic                                          dsmValid,
   output logic                                          dsmTaken,
   output logic                                          dropPulse
);

   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

   typedef struct packed {
      logic [MASTER_ID_WIDTH-1:0] id;
      logic [ADDRESS_WIDTH-1:0]   address;
      logic [DATA_WIDTH-1:0]      data;
      logic                       write;
   } req_t;

   typedef struct packed {
      logic [MASTER_ID_WIDTH-1:0] id;
      logic [DATA_WIDTH-1:0]      data;
   } rsp_t;

   req_t                   r_dms;
   logic                   r_dms_valid;
   logic [IDX_W-1:0]       r_last;
   logic                   r_drop;

   logic                   w_load;
   logic                   w_any;
   logic [IDX_W-1:0]       w_winner;
   req_t                   w_req;
   rsp_t                   w_rsp;
   int unsigned            w_owner;
   logic                   w_owned;
   logic [IDX_W-1:0]       w_owner_idx;
   logic [NUM_MASTERS-1:0] w_sel;

   // Register may be (re)loaded when empty or when its contents leave this cycle.
   assign w_load = !r_dms_valid || dmsTaken;

   mem_arbiter_rr_grant #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (IDX_W)
   ) u_rr_grant (
      .valid  (umsValid),
      .last   (r_last),
      .winner (w_winner),
      .any    (w_any)
   );

   // Accept only the winner, and only when the output register can load.
   always_comb begin
      umsTaken = '0;
      if (w_load && w_any) begin
         umsTaken = NUM_MASTERS'(1) << w_winner;
      end
   end

   // Gather the winner's request fields.
   always_comb begin
      w_req.id      = umsID[w_winner];
      w_req.address = umsAddress[w_winner];
      w_req.data    = umsData[w_winner];
      w_req.write   = umsWrite[w_winner];
   end

   // Output request register and round-robin pointer; reset puts port 0 first.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_dms       <= '0;
         r_dms_valid <= 1'b0;
         r_last      <= IDX_W'(NUM_MASTERS - 1);
      end else if (w_load) begin
         if (w_any) begin
            r_dms       <= w_req;
            r_dms_valid <= 1'b1;
            r_last      <= w_winner;
         end else begin
            r_dms_valid <= 1'b0;
         end
      end
   end

   assign dmsID      = r_dms.id;
   assign dmsAddress = r_dms.address;
   assign dmsData    = r_dms.data;
   assign dmsWrite   = r_dms.write;
   assign dmsValid   = r_dms_valid;

   // Decode the response owner; out-of-range IDs select no port.
   always_comb begin
      w_rsp.id    = dsmID;
      w_rsp.data  = dsmData;
      w_owner     = owner_of(32'(dsmID), ID_SPAN);
      w_owned     = w_owner < NUM_MASTERS;
      w_owner_idx = IDX_W'(w_owner);
      w_sel       = w_owned ? (NUM_MASTERS'(1) << w_owner_idx) : '0;
   end

   // Payload is broadcast; only the owner sees valid. Unowned responses are sunk.
   always_comb begin
      usmID    = {NUM_MASTERS{w_rsp.id}};
      usmData  = {NUM_MASTERS{w_rsp.data}};
      usmValid = w_sel & {NUM_MASTERS{dsmValid}};
      dsmTaken = w_owned ? |(usmTaken & w_sel) : 1'b1;
   end

   // Flag a discarded unowned response one cycle after it is consumed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_drop <= 1'b0;
      end else begin
         r_drop <= dsmValid && !w_owned;
      end
   end

   assign dropPulse = r_drop;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (2 masters, ID_SPAN 4).
module tb_mem_arbiter;

   localparam int unsigned NM  = 2;
   localparam int unsigned DW  = 24;
   localparam int unsigned AW  = 32;
   localparam int unsigned IW  = 8;
   localparam int unsigned SPN = 4;

   logic                         clock = 1'b0;
   logic                         reset = 1'b0;
   logic [NM-1:0][IW-1:0]        umsID      = '0;
   logic [NM-1:0][AW-1:0]        umsAddress = '0;
   logic [NM-1:0][DW-1:0]        umsData    = '0;
   logic [NM-1:0]                umsWrite   = '0;
   logic [NM-1:0]                umsValid   = '0;
   logic [NM-1:0]                umsTaken;
   logic [NM-1:0][IW-1:0]        usmID;
   logic [NM-1:0][DW-1:0]        usmData;
   logic [NM-1:0]                usmValid;
   logic [NM-1:0]                usmTaken   = '0;
   logic [IW-1:0]                dmsID;
   logic [AW-1:0]                dmsAddress;
   logic [DW-1:0]                dmsData;
   logic                         dmsWrite;
   logic                         dmsValid;
   logic                         dmsTaken   = 1'b0;
   logic [IW-1:0]                dsmID      = '0;
   logic [DW-1:0]                dsmData    = '0;
   logic                         dsmValid   = 1'b0;
   logic                         dsmTaken;
   logic                         dropPulse;

   int n_cmp = 0;
   int n_err = 0;

   mem_arbiter #(
      .NUM_MASTERS     (NM),
      .DATA_WIDTH      (DW),
      .ADDRESS_WIDTH   (AW),
      .MASTER_ID_WIDTH (IW),
      .ID_SPAN         (SPN)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .umsID      (umsID),
      .umsAddress (umsAddress),
      .umsData    (umsData),
      .umsWrite   (umsWrite),
      .umsValid   (umsValid),
      .umsTaken   (umsTaken),
      .usmID      (usmID),
      .usmData    (usmData),
      .usmValid   (usmValid),
      .usmTaken   (usmTaken),
      .dmsID      (dmsID),
      .dmsAddress (dmsAddress),
      .dmsData    (dmsData),
      .dmsWrite   (dmsWrite),
      .dmsValid   (dmsValid),
      .dmsTaken   (dmsTaken),
      .dsmID      (dsmID),
      .dsmData    (dsmData),
      .dsmValid   (dsmValid),
      .dsmTaken   (dsmTaken),
      .dropPulse  (dropPulse)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // reset state
      #2;
      check("rst_dmsValid", 64'(dmsValid), 64'd0);
      check("rst_dmsAddress", 64'(dmsAddress), 64'd0);
      check("rst_dmsID", 64'(dmsID), 64'd0);
      check("rst_dropPulse", 64'(dropPulse), 64'd0);
      dmsTaken = 1'b1;
      #10 reset = 1'b1;
      tick();

      // single request from port 0
      umsID[0] = 8'd0; umsAddress[0] = 32'h100; umsData[0] = 24'hABCDEF;
      umsWrite[0] = 1'b1; umsValid[0] = 1'b1;
      #1;
      check("single_taken", 64'(umsTaken), 64'b01);
      tick();
      umsValid[0] = 1'b0;
      #1;
      check("single_valid", 64'(dmsValid), 64'd1);
      check("single_addr", 64'(dmsAddress), 64'h100);
      check("single_data", 64'(dmsData), 64'hABCDEF);
      check("single_id", 64'(dmsID), 64'd0);
      check("single_write", 64'(dmsWrite), 64'd1);
      check("single_idle_taken", 64'(umsTaken), 64'd0);
      tick();
      check("single_drop_valid", 64'(dmsValid), 64'd0);

      // contention: port 0 just won, so rotation starts at port 1
      umsID[0] = 8'd1; umsAddress[0] = 32'h200; umsData[0] = 24'h000111; umsWrite[0] = 1'b0;
      umsID[1] = 8'd6; umsAddress[1] = 32'h300; umsData[1] = 24'h000222; umsWrite[1] = 1'b1;
      umsValid = 2'b11;
      #1;
      for (int c = 0; c < 6; c++) begin
         check($sformatf("cont_grant%0d", c), 64'(umsTaken), (c % 2 == 0) ? 64'b10 : 64'b01);
         if (c > 0) begin
            check($sformatf("cont_valid%0d", c), 64'(dmsValid), 64'd1);
            check($sformatf("cont_id%0d", c), 64'(dmsID), (c % 2 == 0) ? 64'd1 : 64'd6);
         end
         tick();
      end

      // backpressure: port 0's request (ID 1) is held
      dmsTaken = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp_taken%0d", c), 64'(umsTaken), 64'd0);
         check($sformatf("bp_id%0d", c), 64'(dmsID), 64'd1);
         check($sformatf("bp_addr%0d", c), 64'(dmsAddress), 64'h200);
         tick();
      end
      dmsTaken = 1'b1;
      #1;
      check("bp_release_grant", 64'(umsTaken), 64'b10);
      tick();
      umsValid = 2'b00;
      #1;
      check("bp_release_id", 64'(dmsID), 64'd6);
      check("bp_release_valid", 64'(dmsValid), 64'd1);
      tick();
      check("bp_drain", 64'(dmsValid), 64'd0);

      // response to port 1 with immediate acceptance
      dsmID = 8'd5; dsmData = 24'h123456; dsmValid = 1'b1; usmTaken = 2'b10;
      #1;
      check("rsp5_usmValid", 64'(usmValid), 64'b10);
      check("rsp5_dsmTaken", 64'(dsmTaken), 64'd1);
      check("rsp5_usmData", 64'(usmData[1]), 64'h123456);
      check("rsp5_usmID", 64'(usmID[1]), 64'd5);

      // response to port 0 stalls until port 0 accepts
      dsmID = 8'd2; usmTaken = 2'b00;
      #1;
      check("rsp2_usmValid", 64'(usmValid), 64'b01);
      check("rsp2_stall", 64'(dsmTaken), 64'd0);
      usmTaken = 2'b10;
      #1;
      check("rsp2_wrong_port", 64'(dsmTaken), 64'd0);
      usmTaken = 2'b01;
      #1;
      check("rsp2_accept", 64'(dsmTaken), 64'd1);
      tick();
      check("rsp2_no_drop", 64'(dropPulse), 64'd0);

      // unowned ID is sunk and flagged one cycle later
      dsmID = 8'h40; usmTaken = 2'b00;
      #1;
      check("drop_dsmTaken", 64'(dsmTaken), 64'd1);
      check("drop_usmValid", 64'(usmValid), 64'd0);
      check("drop_not_yet", 64'(dropPulse), 64'd0);
      tick();
      dsmValid = 1'b0;
      #1;
      check("drop_pulse", 64'(dropPulse), 64'd1);
      tick();
      check("drop_pulse_end", 64'(dropPulse), 64'd0);

      // reset mid-operation discards the held request
      umsID[1] = 8'd7; umsValid = 2'b10; dmsTaken = 1'b0;
      #1;
      check("mid_grant", 64'(umsTaken), 64'b10);
      tick();
      umsValid = 2'b00;
      #1;
      check("mid_held", 64'(dmsValid), 64'd1);
      check("mid_held_id", 64'(dmsID), 64'd7);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(dmsValid), 64'd0);
      check("mid_rst_id", 64'(dmsID), 64'd0);
      umsValid = 2'b11; dmsTaken = 1'b1;
      #1 reset = 1'b1;
      #1;
      check("post_rst_grant", 64'(umsTaken), 64'b01);
      tick();
      check("post_rst_id", 64'(dmsID), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
